// File: rtl/nonce_scheduler.sv
// rtl/nonce_scheduler.sv - candidate issue, in-flight tagging and first-hit capture for the SHA-256 nonce pipeline
//
// Purpose:
//   Sweeps nonces from nonce_start to nonce_end (inclusive, wrapping mod 2^NONCE_W).
//   One candidate block {prefix, nonce} is issued per clock on hash_in.
//   A valid/nonce tag shift register tracks each candidate for PIPE_DEPTH clocks, so the
//   digest on hash_out can be matched to the nonce that produced it.
//   The first digest below target is captured, and the sweep then stops.
//
// Ports:
//   clk, rst                       clock and synchronous active-high reset
//   start, abort                   sweep control
//   prefix, nonce_start,
//   nonce_end, target              sweep parameters, latched on start
//   hash_in                        candidate block to the pipeline
//   hash_out                       digest from the pipeline, PIPE_DEPTH clocks after hash_in
//   busy, done                     status: busy in ISSUE/DRAIN, done in DONE
//   found, found_nonce, found_hash first-hit result
//   hash_count                     digests checked this sweep, saturating
module nonce_scheduler #(
    parameter int PIPE_DEPTH = 64,
    parameter int NONCE_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [255-NONCE_W:0]  prefix,
    input  logic [NONCE_W-1:0]    nonce_start,
    input  logic [NONCE_W-1:0]    nonce_end,
    input  logic [255:0]          target,
    output logic [255:0]          hash_in,
    input  logic [255:0]          hash_out,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [NONCE_W-1:0]    found_nonce,
    output logic [255:0]          found_hash,
    output logic [31:0]           hash_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]             state;
    logic [255-NONCE_W:0]   prefix_q;
    logic [NONCE_W-1:0]     nonce_q;
    logic [NONCE_W-1:0]     end_q;
    logic [255:0]           target_q;
    logic [PIPE_DEPTH-1:0]  tag_v;
    logic [NONCE_W-1:0]     tag_n [PIPE_DEPTH];

    logic                   issue;
    logic                   running;
    logic                   check;
    logic                   hit;

    assign hash_in = {prefix_q, nonce_q};

    assign issue   = (state == ISSUE);
    assign running = (state == ISSUE) || (state == DRAIN);
    // Digest at the pipe exit belongs to the oldest tag; bubbles are never compared.
    assign check   = running && tag_v[PIPE_DEPTH-1];
    assign hit     = (state != IDLE) && tag_v[PIPE_DEPTH-1] && (hash_out < target_q);

    // Tag nonces carry no meaning without their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        tag_n[0] <= nonce_q;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            tag_n[i] <= tag_n[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prefix_q    <= '0;
            nonce_q     <= '0;
            end_q       <= '0;
            target_q    <= '0;
            tag_v       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            hash_count  <= '0;
        end else begin
            tag_v <= {tag_v[PIPE_DEPTH-2:0], issue};

            if (check && (hash_count != 32'hFFFF_FFFF)) begin
                hash_count <= hash_count + 32'd1;
            end

            case (state)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        prefix_q   <= prefix;
                        nonce_q    <= nonce_start;
                        end_q      <= nonce_end;
                        target_q   <= target;
                        found      <= 1'b0;
                        hash_count <= '0;
                        tag_v      <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The end nonce is held on hash_in through DRAIN; nothing is issued then.
                    if (nonce_q != end_q) begin
                        nonce_q <= nonce_q + 1'b1;
                    end else begin
                        state <= DRAIN;
                    end
                end
                default: begin
                    // Leave once the last valid tag is being checked now, so done lands
                    // PIPE_DEPTH+1 clocks after the final issue.
                    if (~|tag_v[PIPE_DEPTH-2:0]) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
            endcase

            // Abort beats a simultaneous hit; both flush every in-flight tag.
            if (running && abort) begin
                tag_v <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
                state <= IDLE;
            end else if (hit) begin
                found       <= 1'b1;
                found_nonce <= tag_n[PIPE_DEPTH-1];
                found_hash  <= hash_out;
                tag_v       <= '0;
                busy        <= 1'b0;
                done        <= 1'b1;
                state       <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_nonce_scheduler.sv
// tb/tb_nonce_scheduler.sv - directed self-checking bench for nonce_scheduler
module tb_nonce_scheduler;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic [223:0]   prefix;
    logic [31:0]    nonce_start;
    logic [31:0]    nonce_end;
    logic [255:0]   target;
    logic [255:0]   hash_in;
    logic [255:0]   hash_out;
    logic           busy;
    logic           done;
    logic           found;
    logic [31:0]    found_nonce;
    logic [255:0]   found_hash;
    logic [31:0]    hash_count;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    nonce_scheduler #(.PIPE_DEPTH(64), .NONCE_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .prefix      (prefix),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .target      (target),
        .hash_in     (hash_in),
        .hash_out    (hash_out),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .found_nonce (found_nonce),
        .found_hash  (found_hash),
        .hash_count  (hash_count)
    );

    // Stand-in digest: nonces 7 and 3 have the two smallest digests, everything else is large.
    function automatic logic [255:0] dig(input logic [31:0] nv);
        logic [31:0] hi;
        if (nv == 32'd3)      hi = 32'h0000_0010;
        else if (nv == 32'd7) hi = 32'h0000_0008;
        else                  hi = 32'h1000_0000 | nv;
        return {hi, 192'd0, nv};
    endfunction

    // 64-stage pipeline model: hash_out in cycle t+64 is the digest of hash_in from cycle t.
    logic [255:0] pipe [64];
    always @(posedge clk) begin
        pipe[0] <= hash_in;
        for (int i = 1; i < 64; i++) pipe[i] <= pipe[i-1];
    end
    assign hash_out = dig(pipe[63][31:0]);

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the bench at the negedge of the first ISSUE cycle.
    task automatic go(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tg);
        nonce_start = ns;
        nonce_end   = ne;
        target      = tg;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    task automatic run_to_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 400) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        prefix = 224'hABCD_0123; nonce_start = '0; nonce_end = '0; target = '0;
        @(negedge clk);
        step();
        rst = 1'b0;
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_found", 256'(found), 256'(0));
        chk("rst_found_nonce", 256'(found_nonce), 256'(0));
        chk("rst_found_hash", found_hash, 256'(0));
        chk("rst_hash_count", 256'(hash_count), 256'(0));
        chk("rst_hash_in", hash_in, 256'(0));

        // 1: range 0..9, target 0 never hits
        go(32'd0, 32'd9, 256'd0);
        chk("t1_busy", 256'(busy), 256'(1));
        chk("t1_hash_in", hash_in, {224'hABCD_0123, 32'd0});
        run_to_done(n);
        chk("t1_done_cycle", 256'(n), 256'(74));
        chk("t1_found", 256'(found), 256'(0));
        chk("t1_count", 256'(hash_count), 256'(10));
        chk("t1_busy_end", 256'(busy), 256'(0));

        // 2: target all-ones, first digest hits
        go(32'd5, 32'd100, {256{1'b1}});
        run_to_done(n);
        chk("t2_done_cycle", 256'(n), 256'(65));
        chk("t2_found", 256'(found), 256'(1));
        chk("t2_found_nonce", 256'(found_nonce), 256'(5));
        chk("t2_found_hash", found_hash, dig(32'd5));
        chk("t2_count", 256'(hash_count), 256'(1));
        repeat (10) step();
        chk("t2_busy_after", 256'(busy), 256'(0));
        chk("t2_done_after", 256'(done), 256'(1));
        chk("t2_count_after", 256'(hash_count), 256'(1));

        // 3: wrapping range
        go(32'hFFFF_FFFE, 32'h0000_0001, 256'd0);
        chk("t3_issue0", 256'(hash_in[31:0]), 256'(32'hFFFF_FFFE));
        step();
        chk("t3_issue1", 256'(hash_in[31:0]), 256'(32'hFFFF_FFFF));
        step();
        chk("t3_issue2", 256'(hash_in[31:0]), 256'(32'h0000_0000));
        step();
        chk("t3_issue3", 256'(hash_in[31:0]), 256'(32'h0000_0001));
        run_to_done(n);
        chk("t3_done_cycle", 256'(n), 256'(65));
        chk("t3_count", 256'(hash_count), 256'(4));
        chk("t3_found", 256'(found), 256'(0));

        // 4: only 3 and 7 qualify; earliest-issued (3) wins
        go(32'd0, 32'd15, {32'h20, 224'd0});
        run_to_done(n);
        chk("t4_done_cycle", 256'(n), 256'(68));
        chk("t4_found", 256'(found), 256'(1));
        chk("t4_found_nonce", 256'(found_nonce), 256'(3));
        chk("t4_found_hash", found_hash, dig(32'd3));
        chk("t4_count", 256'(hash_count), 256'(4));

        // 5: abort mid-sweep; stale digests of 3 and 7 must not hit the next sweep
        go(32'd0, 32'd999, 256'd0);
        repeat (20) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_busy", 256'(busy), 256'(0));
        chk("t5_abort_done", 256'(done), 256'(0));
        chk("t5_abort_found", 256'(found), 256'(0));
        go(32'd100, 32'd109, {32'h20, 224'd0});
        run_to_done(n);
        chk("t5_done_cycle", 256'(n), 256'(74));
        chk("t5_found", 256'(found), 256'(0));
        chk("t5_count", 256'(hash_count), 256'(10));

        // 6: start while busy is ignored, reset mid-DRAIN, then single-nonce range
        prefix = 224'h1234;
        go(32'd0, 32'd4, 256'd0);
        repeat (30) step();
        chk("t6_busy_drain", 256'(busy), 256'(1));
        prefix = 224'h9999;
        nonce_start = 32'd500;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_start_ignored", hash_in, {224'h1234, 32'd4});
        chk("t6_still_busy", 256'(busy), 256'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_busy", 256'(busy), 256'(0));
        chk("t6_rst_done", 256'(done), 256'(0));
        chk("t6_rst_count", 256'(hash_count), 256'(0));
        chk("t6_rst_hash_in", hash_in, 256'(0));
        prefix = 224'h1234;
        // target equal to the only digest: strict compare, no hit
        go(32'd3, 32'd3, dig(32'd3));
        step();
        chk("t6_single_hold", 256'(hash_in[31:0]), 256'(3));
        run_to_done(n);
        chk("t6_done_cycle", 256'(n), 256'(64));
        chk("t6_found", 256'(found), 256'(0));
        chk("t6_count", 256'(hash_count), 256'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
